// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath bundle for the multicycle MIPS control FSM
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM of the multicycle MIPS core
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       mem_req_c, memwrite_c, irwrite_c, regwrite_c, pcwrite_c, branch_c;
  logic       iord_c, regdst_c, memtoreg_c, alusrca_c;
  logic [1:0] alusrcb_c, aluop_c, pcsrc_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    mem_req_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    iord_c     = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluop_c    = 2'b00;
    pcsrc_c    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = bus.mem_ready;
        pcwrite_c = bus.mem_ready;
        state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alusrcb_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        if (bus.op == OP_LW)      state_d = S_MEMRD;
        else if (bus.op == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        state_d   = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        state_d    = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b01;
        pcsrc_c   = 2'b01;
        branch_c  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JEX: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset_n so they drop the instant reset asserts.
  assign bus.mem_req  = reset_n & mem_req_c;
  assign bus.memwrite = reset_n & memwrite_c;
  assign bus.irwrite  = reset_n & irwrite_c;
  assign bus.regwrite = reset_n & regwrite_c;
  assign bus.pcen     = reset_n & (pcwrite_c | (branch_c & bus.zero));
  assign bus.iord     = iord_c;
  assign bus.regdst   = regdst_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluop    = aluop_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] o;
  } cyc_t;

  cyc_t exp_q[$];

  // Output vector order: mem_req memwrite iord irwrite regdst memtoreg regwrite alusrca alusrcb aluop pcsrc pcen
  function automatic logic [14:0] mk(input logic mr, mw, io, ir, rd, mt, rw, sa,
                                     input logic [1:0] sb, ao, ps, input logic pe);
    return {mr, mw, io, ir, rd, mt, rw, sa, sb, ao, ps, pe};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.state, bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcen};
  endfunction

  task automatic add(input logic [3:0] st, input logic [5:0] op, input logic rdy,
                     input logic z, input logic [14:0] o);
    cyc_t c;
    c.st = st; c.op = op; c.rdy = rdy; c.z = z; c.o = o;
    exp_q.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: expands one instruction into its expected cycle stream.
  task automatic build_instr(input logic [5:0] op, input logic z, input int fs, input int ms);
    for (int i = 0; i < fs; i++) add(4'd0, op, 1'b0, rb(), mk(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
    add(4'd0, op, 1'b1, rb(), mk(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1));
    add(4'd1, op, rb(), rb(), mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
    case (op)
      OP_LW: begin
        add(4'd2, op, rb(), rb(), mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        for (int i = 0; i < ms; i++) add(4'd3, op, 1'b0, rb(), mk(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        add(4'd3, op, 1'b1, rb(), mk(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        add(4'd4, op, rb(), rb(), mk(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
      end
      OP_SW: begin
        add(4'd2, op, rb(), rb(), mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        for (int i = 0; i < ms; i++) add(4'd5, op, 1'b0, rb(), mk(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        add(4'd5, op, 1'b1, rb(), mk(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
      end
      OP_RTYPE: begin
        add(4'd6, op, rb(), rb(), mk(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
        add(4'd7, op, rb(), rb(), mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
      end
      OP_BEQ:  add(4'd8, op, rb(), z, mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,z));
      OP_ADDI: begin
        add(4'd9, op, rb(), rb(), mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
        add(4'd10, op, rb(), rb(), mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
      end
      OP_J:    add(4'd11, op, rb(), rb(), mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1));
      default: ;
    endcase
  endtask

  task automatic apply(input cyc_t c);
    @(negedge clk);
    bus.op = c.op; bus.zero = c.z; bus.mem_ready = c.rdy;
    #1;
  endtask

  task automatic test_reset();
    cyc_t c;
    logic [18:0] want;
    #1;
    want = {4'd0, mk(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)};
    checks++;
    if (observed() !== want) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", observed(), want);
    end
    @(negedge clk); reset_n = 1'b1;
    build_instr(OP_SW, 1'b0, 0, 3);
    for (int i = 0; i < 4; i++) begin
      c = exp_q.pop_front();
      apply(c);
      checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL reset_pre cyc%0d: got %b want %b", i, observed(), {c.st, c.o});
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.memwrite !== 1'b0 || bus.pcen !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got st=%0d mw=%b pcen=%b mr=%b want st=0 mw=0 pcen=0 mr=0",
               bus.state, bus.memwrite, bus.pcen, bus.mem_req);
    end
    exp_q.delete();
    bus.mem_ready = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_lw();
    cyc_t c;
    build_instr(OP_LW, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL lw st%0d: got %b want %b", c.st, observed(), {c.st, c.o});
      end
    end
  endtask

  task automatic test_rtype();
    cyc_t c;
    build_instr(OP_RTYPE, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL rtype st%0d: got %b want %b", c.st, observed(), {c.st, c.o});
      end
    end
  endtask

  task automatic test_beq();
    cyc_t c;
    build_instr(OP_BEQ, 1'b1, 0, 0);
    build_instr(OP_BEQ, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL beq st%0d z=%b: got %b want %b", c.st, c.z, observed(), {c.st, c.o});
      end
    end
  endtask

  task automatic test_stall();
    cyc_t c;
    build_instr(OP_ADDI, 1'b0, 3, 0);
    build_instr(OP_SW, 1'b0, 1, 3);
    build_instr(OP_LW, 1'b0, 2, 2);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL stall st%0d rdy=%b: got %b want %b", c.st, c.rdy, observed(), {c.st, c.o});
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    build_instr(OP_BAD, 1'b0, 0, 0);
    build_instr(OP_J, 1'b0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL illegal st%0d op=%b: got %b want %b", c.st, c.op, observed(), {c.st, c.o});
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == OP_BAD) begin
        op = 6'($urandom);
        if (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) op = OP_BAD;
      end
      build_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front(); apply(c); checks++;
      if (observed() !== {c.st, c.o}) begin
        errors++;
        $display("FAIL random st%0d op=%b: got %b want %b", c.st, c.op, observed(), {c.st, c.o});
      end
    end
  endtask

  initial begin
    bus.op = OP_RTYPE; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_stall();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
